// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Pipeline hazard controller sitting beside the IF/ID, ID/EX and EX/MEM
//   registers. It resolves three hazards:
//     - load-use: a load in EX writes a register that ID reads, so one bubble
//       is inserted.
//     - redirect: a taken branch or jump is resolved in EX, so the younger
//       stages are flushed for FLUSH_CYCLES cycles.
//     - memory wait: a load/store in MEM is still waiting on data memory, so
//       the whole front of the pipe is frozen.
//   It also raises a sticky timeout when a memory wait runs too long.
//   It keeps saturating statistics of stall cycles and accepted redirects.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   IFID_rs1/rs2, uses_*    source registers of the instruction in ID
//   IDEX_MemRead, IDEX_Rd   load flag and destination of the instruction in EX
//   EX_redirect             branch taken / jump resolved in EX this cycle
//   EXMEM_MemReq            MEM stage holds a load or store
//   dmem_ready              data memory completes the access this cycle
//   clear_counters          synchronous clear of the statistics counters
//   pc_write .. exmem_write per-stage write enables (1 = advance)
//   ifid_flush, idex_flush  insert NOP / bubble into IF/ID and ID/EX
//   mem_timeout             sticky: a memory wait reached MEM_TIMEOUT cycles
//   stall_cycles            cycles with pc_write = 0 (saturating)
//   flush_events            accepted redirects (saturating)
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_uses_rs1,
    input  logic             IFID_uses_rs2,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rd,
    input  logic             EX_redirect,
    input  logic             EXMEM_MemReq,
    input  logic             dmem_ready,
    input  logic             clear_counters,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        MEM_WAIT
    } state_t;

    localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WAIT_LIMIT   = 16'(MEM_TIMEOUT);
    localparam logic [15:0] WAIT_MAX     = 16'hFFFF;

    state_t          state_q, state_d;
    logic [3:0]      flushCnt_q, flushCnt_d;
    logic [15:0]     waitCnt_q, waitCnt_d;
    logic            retFlush_q, retFlush_d;
    logic            memTimeout_q;
    logic [CNT_W-1:0] stallCnt_q;
    logic [CNT_W-1:0] flushEvCnt_q;

    logic freeze;
    logic loadUse;
    logic inFlush;
    logic redirectAccepted;
    logic pcWr, ifidWr, idexWr, exmemWr, ifidFl, idexFl;

    // A memory access still outstanding in MEM freezes everything upstream.
    assign freeze = EXMEM_MemReq & ~dmem_ready;

    // Load in EX whose destination is read by the instruction in ID.
    // x0 is hardwired to zero so it never creates a dependency.
    assign loadUse = IDEX_MemRead && (IDEX_Rd != 5'd0) &&
                     ((IFID_uses_rs1 && (IFID_rs1 == IDEX_Rd)) ||
                      (IFID_uses_rs2 && (IFID_rs2 == IDEX_Rd)));

    // While waiting on memory the flush sequence is parked; when the wait
    // ends we resume in whichever mode we were in before the freeze.
    assign inFlush = (state_q == FLUSH) || ((state_q == MEM_WAIT) && retFlush_q);

    // Next-state and control decode. Priority is freeze, then redirect, then
    // an ongoing flush, then load-use.
    always_comb begin
        state_d          = state_q;
        flushCnt_d       = flushCnt_q;
        waitCnt_d        = waitCnt_q;
        retFlush_d       = retFlush_q;
        redirectAccepted = 1'b0;
        pcWr             = 1'b1;
        ifidWr           = 1'b1;
        idexWr           = 1'b1;
        exmemWr          = 1'b1;
        ifidFl           = 1'b0;
        idexFl           = 1'b0;

        if (freeze) begin
            pcWr    = 1'b0;
            ifidWr  = 1'b0;
            idexWr  = 1'b0;
            exmemWr = 1'b0;
            if (state_q == MEM_WAIT) begin
                if (waitCnt_q != WAIT_MAX) begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end else begin
                state_d    = MEM_WAIT;
                retFlush_d = (state_q == FLUSH);
                waitCnt_d  = 16'd1;
            end
        end else begin
            waitCnt_d = 16'd0;
            state_d   = inFlush ? FLUSH : RUN;
            if (EX_redirect) begin
                ifidFl           = 1'b1;
                idexFl           = 1'b1;
                redirectAccepted = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d    = FLUSH;
                    flushCnt_d = FLUSH_RELOAD;
                end else begin
                    state_d = RUN;
                end
            end else if (inFlush) begin
                ifidFl     = 1'b1;
                idexFl     = 1'b1;
                flushCnt_d = flushCnt_q - 4'd1;
                if (flushCnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end else if (loadUse) begin
                pcWr   = 1'b0;
                ifidWr = 1'b0;
                idexFl = 1'b1;
            end
        end
    end

    // State, counters and sticky timeout. The timeout is set on the edge that
    // completes the MEM_TIMEOUT-th consecutive wait cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            flushCnt_q   <= 4'd0;
            waitCnt_q    <= 16'd0;
            retFlush_q   <= 1'b0;
            memTimeout_q <= 1'b0;
            stallCnt_q   <= '0;
            flushEvCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            waitCnt_q  <= waitCnt_d;
            retFlush_q <= retFlush_d;
            if (waitCnt_d == WAIT_LIMIT) begin
                memTimeout_q <= 1'b1;
            end
            if (clear_counters) begin
                stallCnt_q <= '0;
            end else if (!pcWr && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
            if (clear_counters) begin
                flushEvCnt_q <= '0;
            end else if (redirectAccepted && (flushEvCnt_q != '1)) begin
                flushEvCnt_q <= flushEvCnt_q + CNT_W'(1);
            end
        end
    end

    // Reset holds the whole pipeline: every control drops to zero at once.
    assign pc_write     = reset & pcWr;
    assign ifid_write   = reset & ifidWr;
    assign idex_write   = reset & idexWr;
    assign exmem_write  = reset & exmemWr;
    assign ifid_flush   = reset & ifidFl;
    assign idex_flush   = reset & idexFl;
    assign mem_timeout  = memTimeout_q;
    assign stall_cycles = stallCnt_q;
    assign flush_events = flushEvCnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Drives directed hazard scenarios followed by random traffic. Each cycle the
// expected response is computed by a behavioural model and queued; a
// separate monitor pops one entry per cycle and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int FLUSH_CYCLES = 3;
    localparam int MEM_TIMEOUT  = 8;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
    localparam int WAIT_MAX     = 65535;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       memRead;
        logic [4:0] rd;
        logic       redir;
        logic       memReq;
        logic       rdy;
        logic       clr;
    } stim_t;

    // ctrl order: pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush
    typedef struct packed {
        logic [31:0]      vecId;
        logic [5:0]       ctrl;
        logic             tmo;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] fev;
    } resp_t;

    logic             clk;
    logic             reset;
    logic [4:0]       IFID_rs1, IFID_rs2, IDEX_Rd;
    logic             IFID_uses_rs1, IFID_uses_rs2, IDEX_MemRead;
    logic             EX_redirect, EXMEM_MemReq, dmem_ready, clear_counters;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    hazard_control_unit #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .IFID_rs1      (IFID_rs1),
        .IFID_rs2      (IFID_rs2),
        .IFID_uses_rs1 (IFID_uses_rs1),
        .IFID_uses_rs2 (IFID_uses_rs2),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_Rd       (IDEX_Rd),
        .EX_redirect   (EX_redirect),
        .EXMEM_MemReq  (EXMEM_MemReq),
        .dmem_ready    (dmem_ready),
        .clear_counters(clear_counters),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_write    (idex_write),
        .exmem_write   (exmem_write),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    resp_t expQ[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    vecCount   = 0;

    // Behavioural model state: how many more flush cycles are owed, length
    // of the current memory wait, statistics and sticky timeout.
    int flushOwed   = 0;
    int waitLen     = 0;
    int stallModel  = 0;
    int flushModel  = 0;
    bit tmoModel    = 1'b0;

    function automatic stim_t idleStim();
        stim_t s;
        s      = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    // Expected response for the current cycle's inputs; model state then
    // advances to what it will be after the next rising edge.
    task automatic modelStep(input stim_t s, output resp_t e);
        bit freeze, loadUse, accept;
        logic [5:0] ctrl;
        if (!s.rstn) begin
            flushOwed  = 0;
            waitLen    = 0;
            stallModel = 0;
            flushModel = 0;
            tmoModel   = 1'b0;
        end
        e.vecId = 32'(vecCount);
        e.tmo   = tmoModel;
        e.stall = CNT_W'(stallModel);
        e.fev   = CNT_W'(flushModel);
        if (!s.rstn) begin
            e.ctrl = 6'b000000;
            return;
        end
        freeze  = s.memReq && !s.rdy;
        loadUse = s.memRead && (s.rd != 0) &&
                  ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        accept  = 1'b0;
        ctrl    = 6'b111100;
        if (freeze) begin
            ctrl = 6'b000000;
        end else if (s.redir) begin
            ctrl      = 6'b111111;
            accept    = 1'b1;
            flushOwed = FLUSH_CYCLES - 1;
        end else if (flushOwed > 0) begin
            ctrl      = 6'b111111;
            flushOwed = flushOwed - 1;
        end else if (loadUse) begin
            ctrl = 6'b001101;
        end
        e.ctrl = ctrl;
        if (freeze) waitLen = (waitLen < WAIT_MAX) ? waitLen + 1 : WAIT_MAX;
        else        waitLen = 0;
        if (waitLen >= MEM_TIMEOUT) tmoModel = 1'b1;
        if (s.clr) begin
            stallModel = 0;
            flushModel = 0;
        end else begin
            if (!ctrl[5] && stallModel < CNT_MAX) stallModel = stallModel + 1;
            if (accept && flushModel < CNT_MAX)   flushModel = flushModel + 1;
        end
    endtask

    // One cycle of stimulus, applied just after the rising edge.
    task automatic applyStimulus(input stim_t s);
        resp_t e;
        @(posedge clk);
        #1;
        reset          = s.rstn;
        IFID_rs1       = s.rs1;
        IFID_rs2       = s.rs2;
        IFID_uses_rs1  = s.u1;
        IFID_uses_rs2  = s.u2;
        IDEX_MemRead   = s.memRead;
        IDEX_Rd        = s.rd;
        EX_redirect    = s.redir;
        EXMEM_MemReq   = s.memReq;
        dmem_ready     = s.rdy;
        clear_counters = s.clr;
        modelStep(s, e);
        expQ.push_back(e);
        vecCount++;
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idleStim());
    endtask

    task automatic checkOutput(input resp_t e);
        resp_t a;
        a.vecId = e.vecId;
        a.ctrl  = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush};
        a.tmo   = mem_timeout;
        a.stall = stall_cycles;
        a.fev   = flush_events;
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL vec%0d outputs: got ctrl=%b tmo=%b stall=%0d fev=%0d, want ctrl=%b tmo=%b stall=%0d fev=%0d",
                     e.vecId, a.ctrl, a.tmo, a.stall, a.fev, e.ctrl, e.tmo, e.stall, e.fev);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        stim_t s;
        reset          = 1'b0;
        IFID_rs1       = '0;
        IFID_rs2       = '0;
        IFID_uses_rs1  = 1'b0;
        IFID_uses_rs2  = 1'b0;
        IDEX_MemRead   = 1'b0;
        IDEX_Rd        = '0;
        EX_redirect    = 1'b0;
        EXMEM_MemReq   = 1'b0;
        dmem_ready     = 1'b0;
        clear_counters = 1'b0;

        // Reset held for a few cycles, then released.
        s = idleStim(); s.rstn = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        applyIdle(2);

        // Load-use on rs2, then the same pattern with Rd = x0.
        s = idleStim(); s.memRead = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        applyStimulus(s);
        applyIdle(2);
        s.rd = 5'd0; s.rs2 = 5'd0;
        applyStimulus(s);
        applyIdle(2);

        // Single redirect, then a second redirect in the second flush cycle.
        s = idleStim(); s.redir = 1'b1;
        applyStimulus(s);
        applyIdle(4);
        applyStimulus(s);
        applyIdle(1);
        applyStimulus(s);
        applyIdle(5);

        // Redirect and load-use in the same cycle.
        s = idleStim(); s.redir = 1'b1; s.memRead = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
        applyStimulus(s);
        applyIdle(4);

        // Four-cycle memory wait with a redirect held throughout.
        s = idleStim(); s.memReq = 1'b1; s.redir = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(s);
        s.rdy = 1'b1;
        applyStimulus(s);
        applyIdle(4);

        // Long wait reaching the timeout; it must survive the wait ending.
        s = idleStim(); s.memReq = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(s);
        applyIdle(3);
        s = idleStim(); s.rstn = 1'b0;
        applyStimulus(s);
        applyIdle(2);

        // Stall saturation, then clear concurrent with a stall.
        s = idleStim(); s.memRead = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(s);
        s.clr = 1'b1;
        applyStimulus(s);
        applyIdle(2);

        // Reset in the middle of a flush sequence.
        s = idleStim(); s.redir = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.rstn = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        applyIdle(4);

        // Freeze arriving during a flush; the flush resumes afterwards.
        s = idleStim(); s.redir = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.memReq = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        applyIdle(4);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            s         = idleStim();
            s.rstn    = ($urandom_range(0, 199) != 0);
            s.clr     = ($urandom_range(0, 29) == 0);
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            s.u1      = 1'($urandom_range(0, 1));
            s.u2      = 1'($urandom_range(0, 1));
            s.memRead = ($urandom_range(0, 2) == 0);
            s.rd      = 5'($urandom_range(0, 3));
            s.redir   = ($urandom_range(0, 5) == 0);
            s.memReq  = ($urandom_range(0, 3) == 0);
            s.rdy     = ($urandom_range(0, 1) == 0);
            applyStimulus(s);
        end

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending responses, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
